// File: rtl/video_fetch.sv
// ---------------------------------------------------------------------------
// video_fetch
//
// Memory-side consumer of the video bus slots. In each slot that belongs to
// video, the fetch FSM reads one 16-bit framebuffer word and pushes it into a
// small word FIFO. A 1-bpp shifter drains the FIFO at the pixel rate and
// emits one registered pixel per enable, MSB first.
//
// Optional feature macro: VIDEO_FETCH_UNDERRUN_EN
//   defined     -> sticky underrun detection. It is cleared by reset or
//                  frame_start.
//   not defined -> underrun tied to 0 and no detection logic is built.
//   An empty FIFO stalls the shifter in both builds.
//
// Ports:
//   clk, reset        16 MHz clock, asynchronous active-high reset
//   clk8_en_p         pixel-rate enable
//   busPhase          bus phase 0..7
//   cycleReady        high at busPhase 7, memory data valid
//   videoBusControl   current slot belongs to video
//   frame_start       reload pointer from base_addr, then start a line
//   line_start        flush FIFO and shifter, rearm fetch/shift counters
//   base_addr         framebuffer word base address
//   mem_data          read data, sampled on the cycleReady edge
//   mem_addr, mem_rd  read address and request, stable for the whole slot
//   pixel             pixel value, 1 = black
//   pixel_valid       pixel is an active-line pixel
//   underrun          sticky FIFO-underrun flag
// ---------------------------------------------------------------------------
module video_fetch #(
    parameter int ADDR_W         = 21,
    parameter int WORDS_PER_LINE = 32,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk8_en_p,
    input  logic [2:0]        busPhase,
    input  logic              cycleReady,
    input  logic              videoBusControl,
    input  logic              frame_start,
    input  logic              line_start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       mem_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              pixel,
    output logic              pixel_valid,
    output logic              underrun
);

    localparam int PTR_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W        = $clog2(FIFO_DEPTH + 1);
    localparam int FETCH_W      = $clog2(WORDS_PER_LINE + 1);
    localparam int PIX_PER_LINE = WORDS_PER_LINE * 16;
    localparam int SHIFT_W      = $clog2(PIX_PER_LINE + 1);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } fetchState_e;

    fetchState_e         fetchState_r;
    fetchState_e         fetchNext_s;
    logic                memRd_s;
    logic [ADDR_W-1:0]   pointer_r;
    logic [FETCH_W-1:0]  fetchLeft_r;
    logic [15:0]         fifoMem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]    wrPtr_r;
    logic [PTR_W-1:0]    rdPtr_r;
    logic [CNT_W-1:0]    fifoCount_r;
    logic [14:0]         shiftReg_r;
    logic [3:0]          bitCount_r;
    logic [SHIFT_W-1:0]  shiftLeft_r;
    logic                pixel_r;
    logic                pixelValid_r;
    logic                restart_s;
    logic                push_s;
    logic                pop_s;
    logic [15:0]         headWord_s;

    // frame_start implies all line_start actions, so either pulse restarts a line
    assign restart_s  = frame_start | line_start;
    // an aborted request never delivers its word
    assign push_s     = (fetchState_r == REQ) && cycleReady && !restart_s;
    assign pop_s      = clk8_en_p && !restart_s && (shiftLeft_r != SHIFT_W'(0)) &&
                        (bitCount_r == 4'd0) && (fifoCount_r != CNT_W'(0));
    assign headWord_s = fifoMem_r[rdPtr_r];

    // fetch FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetchState_r <= IDLE;
        end else begin
            fetchState_r <= fetchNext_s;
        end
    end

    // fetch FSM next state: a slot is claimed only at its phase 0, and only with FIFO room
    always_comb begin
        fetchNext_s = fetchState_r;
        case (fetchState_r)
            IDLE: begin
                if (!restart_s && videoBusControl && (busPhase == 3'd0) &&
                    (fetchLeft_r != FETCH_W'(0)) && (fifoCount_r < CNT_W'(FIFO_DEPTH))) begin
                    fetchNext_s = REQ;
                end else begin
                    fetchNext_s = IDLE;
                end
            end
            REQ: begin
                if (restart_s || cycleReady) begin
                    fetchNext_s = IDLE;
                end else begin
                    fetchNext_s = REQ;
                end
            end
            default: fetchNext_s = IDLE;
        endcase
    end

    // fetch FSM outputs: request follows the state bit directly
    always_comb begin
        memRd_s = 1'b0;
        if (fetchState_r == REQ) begin
            memRd_s = 1'b1;
        end else begin
            memRd_s = 1'b0;
        end
    end

    assign mem_rd   = memRd_s;
    // pointer only moves on the slot-ending edge or on a restart, so the address is slot-stable
    assign mem_addr = pointer_r;

    // word pointer and remaining-fetch counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pointer_r   <= '0;
            fetchLeft_r <= '0;
        end else if (frame_start) begin
            pointer_r   <= base_addr;
            fetchLeft_r <= FETCH_W'(WORDS_PER_LINE);
        end else if (line_start) begin
            fetchLeft_r <= FETCH_W'(WORDS_PER_LINE);
        end else if (push_s) begin
            pointer_r   <= pointer_r + ADDR_W'(1);
            fetchLeft_r <= fetchLeft_r - FETCH_W'(1);
        end
    end

    // FIFO storage (data needs no reset; occupancy governs validity)
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifoMem_r[wrPtr_r] <= mem_data;
        end
    end

    // FIFO pointers and occupancy; push and pop together leave occupancy unchanged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_r     <= '0;
            rdPtr_r     <= '0;
            fifoCount_r <= '0;
        end else if (restart_s) begin
            wrPtr_r     <= '0;
            rdPtr_r     <= '0;
            fifoCount_r <= '0;
        end else begin
            if (push_s) begin
                wrPtr_r <= wrPtr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rdPtr_r <= rdPtr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   fifoCount_r <= fifoCount_r + CNT_W'(1);
                2'b01:   fifoCount_r <= fifoCount_r - CNT_W'(1);
                default: fifoCount_r <= fifoCount_r;
            endcase
        end
    end

    // pixel shifter: an empty FIFO stalls without consuming a line pixel
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shiftReg_r   <= '0;
            bitCount_r   <= 4'd0;
            shiftLeft_r  <= '0;
            pixel_r      <= 1'b0;
            pixelValid_r <= 1'b0;
        end else if (restart_s) begin
            shiftReg_r   <= '0;
            bitCount_r   <= 4'd0;
            shiftLeft_r  <= SHIFT_W'(PIX_PER_LINE);
            pixel_r      <= 1'b0;
            pixelValid_r <= 1'b0;
        end else if (clk8_en_p) begin
            if (shiftLeft_r == SHIFT_W'(0)) begin
                pixel_r      <= 1'b0;
                pixelValid_r <= 1'b0;
            end else if (bitCount_r != 4'd0) begin
                pixel_r      <= shiftReg_r[14];
                shiftReg_r   <= {shiftReg_r[13:0], 1'b0};
                bitCount_r   <= bitCount_r - 4'd1;
                pixelValid_r <= 1'b1;
                shiftLeft_r  <= shiftLeft_r - SHIFT_W'(1);
            end else if (fifoCount_r != CNT_W'(0)) begin
                pixel_r      <= headWord_s[15];
                shiftReg_r   <= headWord_s[14:0];
                bitCount_r   <= 4'd15;
                pixelValid_r <= 1'b1;
                shiftLeft_r  <= shiftLeft_r - SHIFT_W'(1);
            end else begin
                pixel_r      <= 1'b0;
                pixelValid_r <= 1'b0;
            end
        end
    end

    assign pixel       = pixel_r;
    assign pixel_valid = pixelValid_r;

`ifdef VIDEO_FETCH_UNDERRUN_EN
    logic starve_s;
    logic underrun_r;

    assign starve_s = clk8_en_p && !restart_s && (shiftLeft_r != SHIFT_W'(0)) &&
                      (bitCount_r == 4'd0) && (fifoCount_r == CNT_W'(0));

    // sticky underrun: only reset or a new frame clears it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun_r <= 1'b0;
        end else if (frame_start) begin
            underrun_r <= 1'b0;
        end else if (starve_s) begin
            underrun_r <= 1'b1;
        end
    end

    assign underrun = underrun_r;
`else
    assign underrun = 1'b0;
`endif

endmodule
